// File: rtl/aes_ctrl_pkg.sv
// Shared constants, types and state encoding for the AES round controller.
package aes_ctrl_pkg;

  localparam int AES128_NR    = 10;
  localparam int DP_ROUND_LAT = 5;
  localparam int BLK_W        = 128;
  localparam int KIDX_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY0,
    S_ROUND,
    S_DONE
  } ctrl_state_e;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [KIDX_W-1:0] kidx_t;

endpackage

// File: rtl/aes_round_timer.sv
// Per-round latency window timer: counts LAT enabled cycles, pulses done
// on the last one and clears itself.
module aes_round_timer #(
  parameter  int LAT = 5,
  localparam int W   = (LAT > 1) ? $clog2(LAT) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [W-1:0] LAST = W'(LAT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || done_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: initial key add, then NR timed passes through
// the T-box round datapath, result held until the consumer takes it.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int ROUND_LAT = DP_ROUND_LAT
) (
  input  logic              bram_clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_data,
  input  logic              in_dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_data,
  output logic              busy,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [BLK_W-1:0]  rk_data,
  output logic [BLK_W-1:0]  dp_din,
  output logic [BLK_W-1:0]  dp_key,
  output logic              dp_e_d,
  output logic              dp_t_s,
  input  logic [BLK_W-1:0]  dp_dout
);

  localparam kidx_t NR_IDX = KIDX_W'(NR);
  localparam kidx_t NR_M1  = KIDX_W'(NR - 1);
  localparam kidx_t K_ONE  = KIDX_W'(1);

  ctrl_state_e fsm_q, fsm_d;
  blk_t        blk_q, blk_d;
  blk_t        out_q, out_d;
  kidx_t       idx_q, idx_d;
  kidx_t       rnd_q, rnd_d;
  kidx_t       rnd_nxt;
  logic        dec_q, dec_d;
  logic        ts_q, ts_d;
  logic        ov_q, ov_d;
  logic        tmr_clr, tmr_en, tmr_done;

  aes_round_timer #(
    .LAT (ROUND_LAT)
  ) u_timer (
    .clk_i  (bram_clk),
    .rst_i  (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  // The key store reads synchronously, so the first index is presented
  // while still idle; the initial-round key is then ready in KEY0.
  assign rk_idx    = (fsm_q == S_IDLE)
                   ? (in_dec ? NR_IDX : '0)
                   : idx_q;
  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q != S_IDLE);
  assign out_valid = ov_q;
  assign out_data  = out_q;
  assign dp_din    = blk_q;
  assign dp_key    = rk_data;
  assign dp_e_d    = dec_q;
  assign dp_t_s    = ts_q;
  assign rnd_nxt   = rnd_q + K_ONE;

  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    out_d   = out_q;
    idx_d   = idx_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    ts_d    = ts_q;
    ov_d    = ov_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d = in_data;
          dec_d = in_dec;
          idx_d = in_dec ? NR_IDX : '0;
          fsm_d = S_KEY0;
        end
      end
      S_KEY0: begin
        blk_d   = blk_q ^ rk_data;
        idx_d   = dec_q ? NR_M1 : K_ONE;
        rnd_d   = K_ONE;
        ts_d    = (NR == 1);
        tmr_clr = 1'b1;
        fsm_d   = S_ROUND;
      end
      S_ROUND: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          blk_d = dp_dout;
          if (rnd_q == NR_IDX) begin
            out_d = dp_dout;
            ov_d  = 1'b1;
            ts_d  = 1'b0;
            fsm_d = S_DONE;
          end else begin
            rnd_d = rnd_nxt;
            idx_d = dec_q ? idx_q - K_ONE : idx_q + K_ONE;
            ts_d  = (rnd_nxt == NR_IDX);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d  = 1'b0;
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bram_clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      blk_q <= '0;
      out_q <= '0;
      idx_q <= '0;
      rnd_q <= '0;
      dec_q <= 1'b0;
      ts_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      out_q <= out_d;
      idx_q <= idx_d;
      rnd_q <= rnd_d;
      dec_q <= dec_d;
      ts_q  <= ts_d;
      ov_q  <= ov_d;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench: behavioural key store and T-box datapath around the sequencer,
// results compared with a straight FIPS-197 cipher model.
module tb_aes_round_sequencer;

  localparam int NR      = 10;
  localparam int LAT     = 5;
  localparam int EXP_LAT = 2 + NR * LAT;

  logic         bram_clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_dec;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] dp_din;
  logic [127:0] dp_key;
  logic         dp_e_d;
  logic         dp_t_s;
  logic [127:0] dp_dout;

  logic [7:0]   sb_t  [256];
  logic [7:0]   isb_t [256];
  logic [127:0] ek [11];
  logic [127:0] dk [11];
  logic [127:0] p1, p2;
  int           n_chk = 0;
  int           n_pass = 0;

  aes_round_sequencer #(
    .NR        (NR),
    .ROUND_LAT (LAT)
  ) dut (
    .bram_clk  (bram_clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dec    (in_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .dp_din    (dp_din),
    .dp_key    (dp_key),
    .dp_e_d    (dp_e_d),
    .dp_t_s    (dp_t_s),
    .dp_dout   (dp_dout)
  );

  initial bram_clk = 1'b0;
  always #5 bram_clk = ~bram_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] cf(input int k, input bit inv);
    case (k)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] subb(input logic [127:0] s,
                                        input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb_t[s[127-8*i -: 8]]
                            : sb_t[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shft(input logic [127:0] s,
                                        input bit inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv)
          o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        else
          o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s,
                                        input bit inv);
    logic [127:0] o;
    logic [7:0]   a;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        a = '0;
        for (int j = 0; j < 4; j++)
          a = a ^ gm(cf((j - r + 4) % 4, inv),
                     s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = a;
      end
    return o;
  endfunction

  // FIPS-197 Cipher / InvCipher, whole block at once.
  function automatic logic [127:0] ref_enc(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ ek[0];
    for (int r = 1; r <= NR; r++) begin
      s = shft(subb(s, 0), 0);
      if (r < NR) s = mixc(s, 0);
      s = s ^ ek[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] c);
    logic [127:0] s;
    s = c ^ ek[NR];
    for (int r = NR - 1; r >= 0; r--) begin
      s = subb(shft(s, 1), 1);
      s = s ^ ek[r];
      if (r > 0) s = mixc(s, 1);
    end
    return s;
  endfunction

  function automatic logic [127:0] dp_rnd(input logic [127:0] din,
                                          input logic [127:0] key,
                                          input logic e_d,
                                          input logic t_s);
    logic [127:0] s;
    s = shft(subb(din, e_d), e_d);
    if (!t_s) s = mixc(s, e_d);
    return s ^ key;
  endfunction

  function automatic logic [127:0] ks_rd(input logic [3:0] i,
                                         input logic d);
    if (i > 4'(NR)) return '0;
    return d ? dk[i] : ek[i];
  endfunction

  // Synchronous key store: one-cycle read latency.
  always @(posedge bram_clk)
    rk_data <= ks_rd(rk_idx, in_ready ? in_dec : dp_e_d);

  // Two-stage pipelined round datapath.
  always @(posedge bram_clk) begin
    p1 <= dp_rnd(dp_din, dp_key, dp_e_d, dp_t_s);
    p2 <= p1;
  end
  assign dp_dout = p2;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic init_tab();
    logic [7:0] x, p, b;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      p = 8'h01;
      if (x == 8'h00) p = 8'h00;
      else repeat (254) p = gm(p, x);
      b = p ^ rl(p, 1) ^ rl(p, 2) ^ rl(p, 3) ^ rl(p, 4) ^ 8'h63;
      sb_t[i]  = b;
      isb_t[b] = x;
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_t[t[31:24]], sb_t[t[23:16]],
             sb_t[t[15:8]], sb_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) begin
      ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      dk[r] = (r == 0 || r == NR) ? ek[r] : mixc(ek[r], 1);
    end
  endtask

  // Offer a block from a negedge; returns right after the accept edge.
  task automatic accept(input string tag, input logic [127:0] d,
                        input logic dec);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_dec   = dec;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge bram_clk);
      n++;
    end
    chk({tag, "_acc"}, 128'(in_ready), 128'(1));
    @(posedge bram_clk);
  endtask

  // Follows one block from its accept edge to out_valid.
  task automatic collect(input string tag, input logic dec,
                         input bit keep, input logic [127:0] nxt,
                         output logic [127:0] res);
    int lat, ts_n, ts_first, ts_last, ed_bad;
    logic [3:0]  tr [$];
    logic [63:0] tg, te;
    lat = 1; ts_n = 0; ts_first = 0; ts_last = 0; ed_bad = 0;
    while (lat < 200) begin
      @(negedge bram_clk);
      if (lat == 1) begin
        if (keep) in_data = nxt;
        else in_valid = 1'b0;
      end
      if (tr.size() == 0 || tr[$] !== rk_idx) tr.push_back(rk_idx);
      if (dp_t_s === 1'b1) begin
        if (ts_n == 0) ts_first = lat;
        ts_last = lat;
        ts_n++;
      end
      if (dp_e_d !== dec) ed_bad++;
      if (out_valid === 1'b1) break;
      @(posedge bram_clk);
      lat++;
    end
    tg = '0;
    te = '0;
    foreach (tr[i]) tg = {tg[59:0], tr[i]};
    for (int i = 0; i <= NR; i++)
      te = {te[59:0], dec ? 4'(NR - i) : 4'(i)};
    chk({tag, "_lat"}, 128'(lat), 128'(EXP_LAT));
    chk({tag, "_trlen"}, 128'(tr.size()), 128'(NR + 1));
    chk({tag, "_trace"}, 128'(tg), 128'(te));
    chk({tag, "_ts_n"}, 128'(ts_n), 128'(LAT));
    chk({tag, "_ts_span"}, 128'(ts_last - ts_first + 1), 128'(LAT));
    chk({tag, "_ts_end"}, 128'(ts_last), 128'(lat - 1));
    chk({tag, "_ed"}, 128'(ed_bad), 128'(0));
    res = out_data;
  endtask

  // Holds the result for `hold` cycles (optionally offering a block),
  // then releases it.
  task automatic drain(input string tag, input int hold, input bit poke,
                       input logic [127:0] res);
    int bad;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (poke) begin
        in_valid = 1'b1;
        in_data  = ~res;
        in_dec   = 1'b0;
      end
      @(negedge bram_clk);
      if (out_valid !== 1'b1 || out_data !== res ||
          in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk({tag, "_hold"}, 128'(bad), 128'(0));
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge bram_clk);
    chk({tag, "_rel"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] r, d, b;
    logic         dec;
    int           n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_dec = 1'b0;
    out_ready = 1'b0;
    init_tab();
    repeat (3) @(posedge bram_clk);
    @(negedge bram_clk);
    rst = 1'b0;
    chk("rst_flags", 128'({in_ready, out_valid, busy, dp_e_d, dp_t_s}),
        128'(5'b10000));
    chk("rst_idx", 128'(rk_idx), 128'(0));
    chk("rst_out", out_data, 128'(0));
    chk("rst_din", dp_din, 128'(0));

    set_key(FK);
    accept("enc", FP, 1'b0);
    collect("enc", 1'b0, 1'b0, '0, r);
    chk("enc_fips", r, FC);
    drain("enc", 0, 1'b0, r);

    accept("dec", FC, 1'b1);
    collect("dec", 1'b1, 1'b0, '0, r);
    chk("dec_fips", r, FP);
    drain("dec", 0, 1'b0, r);

    accept("bp", FP, 1'b0);
    collect("bp", 1'b0, 1'b0, '0, r);
    chk("bp_data", r, FC);
    drain("bp", 20, 1'b1, r);

    accept("mid", FP, 1'b0);
    n = 0;
    while (rk_idx !== 4'd3 && n < 100) begin
      @(negedge bram_clk);
      in_valid = 1'b0;
      n++;
    end
    chk("mid_r3", 128'(rk_idx), 128'(3));
    @(negedge bram_clk);
    rst = 1'b1;
    @(negedge bram_clk);
    rst = 1'b0;
    chk("mid_rst", 128'({in_ready, out_valid, busy, dp_t_s}),
        128'(4'b1000));
    chk("mid_idx", 128'(rk_idx), 128'(0));
    accept("post", FP, 1'b0);
    collect("post", 1'b0, 1'b0, '0, r);
    chk("post_fips", r, FC);
    drain("post", 0, 1'b0, r);

    b = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    accept("b2b1", FP, 1'b0);
    collect("b2b1", 1'b0, 1'b1, b, r);
    chk("b2b1_data", r, FC);
    @(negedge bram_clk);
    chk("b2b_gap", 128'({in_ready, in_valid}), 128'(2'b11));
    @(posedge bram_clk);
    collect("b2b2", 1'b0, 1'b0, '0, r);
    chk("b2b2_data", r, ref_enc(b));
    drain("b2b2", 0, 1'b0, r);

    for (int k = 0; k < 6; k++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      d   = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      accept("rnd", d, dec);
      collect("rnd", dec, 1'b0, '0, r);
      chk("rnd_data", r, dec ? ref_dec(d) : ref_enc(d));
      drain("rnd", k, 1'b0, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
